// File: rtl/exec_pkg.sv
// Shared encodings for the E stage: ALU ops, multiply/divide ops, HI/LO result select and
// forwarding-mux selects.
package exec_pkg;

  localparam logic [2:0] ALU_ADDU = 3'd0;
  localparam logic [2:0] ALU_SUBU = 3'd1;
  localparam logic [2:0] ALU_AND  = 3'd2;
  localparam logic [2:0] ALU_OR   = 3'd3;
  localparam logic [2:0] ALU_XOR  = 3'd4;
  localparam logic [2:0] ALU_SLT  = 3'd5;
  localparam logic [2:0] ALU_ADD  = 3'd6;  // signed add, overflow-checked when enabled
  localparam logic [2:0] ALU_SUB  = 3'd7;  // signed sub, overflow-checked when enabled

  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  localparam logic [1:0] HILO_ALU = 2'd0;
  localparam logic [1:0] HILO_HI  = 2'd1;
  localparam logic [1:0] HILO_LO  = 2'd2;

  localparam logic [1:0] FWD_RD = 2'd0;
  localparam logic [1:0] FWD_W  = 2'd1;
  localparam logic [1:0] FWD_M  = 2'd2;

  function automatic logic md_is_mul(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic md_is_long(input logic [2:0] op);
    return (op >= MD_MULT) && (op <= MD_DIVU);
  endfunction

endpackage

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit: operand latches, latency counter, HI/LO registers and the
// busy handshake towards the hazard unit.
module md_unit import exec_pkg::*; #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MUL_LAT = 5,
  parameter int unsigned DIV_LAT = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid_i,
  input  logic [2:0]        md_op_i,
  input  logic [DATA_W-1:0] src_a_i,
  input  logic [DATA_W-1:0] src_b_i,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic              md_busy_o
);

  localparam int unsigned MaxLat = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned CntW   = $clog2(MaxLat + 1);

  typedef enum logic [0:0] {StIdle, StRun} md_state_e;

  md_state_e         state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;

  logic busy_q;
  logic md_start;
  assign busy_q    = (state_q == StRun);
  assign md_start  = ex_valid_i & ~busy_q & md_is_long(md_op_i);
  assign md_busy_o = busy_q | md_start;

  logic                signed_op;
  logic [2*DATA_W-1:0] ext_a, ext_b, prod;
  assign signed_op = (op_q == MD_MULT) || (op_q == MD_DIV);
  assign ext_a     = {{DATA_W{signed_op & a_q[DATA_W-1]}}, a_q};
  assign ext_b     = {{DATA_W{signed_op & b_q[DATA_W-1]}}, b_q};
  assign prod      = ext_a * ext_b;

  // Signed divide via magnitudes; INT_MIN/-1 falls out naturally as INT_MIN rem 0.
  logic              a_neg, b_neg, div_zero;
  logic [DATA_W-1:0] mag_a, mag_b, divisor, quo_u, rem_u, quo, rem;
  assign a_neg    = signed_op & a_q[DATA_W-1];
  assign b_neg    = signed_op & b_q[DATA_W-1];
  assign mag_a    = a_neg ? -a_q : a_q;
  assign mag_b    = b_neg ? -b_q : b_q;
  assign div_zero = (b_q == '0);
  assign divisor  = div_zero ? DATA_W'(1) : mag_b;
  assign quo_u    = mag_a / divisor;
  assign rem_u    = mag_a % divisor;
  assign quo      = (a_neg ^ b_neg) ? -quo_u : quo_u;
  assign rem      = a_neg ? -rem_u : rem_u;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      StIdle: begin
        if (md_start) begin
          state_d = StRun;
          op_d    = md_op_i;
          a_d     = src_a_i;
          b_d     = src_b_i;
          cnt_d   = md_is_mul(md_op_i) ? CntW'(MUL_LAT - 1) : CntW'(DIV_LAT - 1);
        end else if (ex_valid_i && (md_op_i == MD_MTHI)) begin
          hi_d = src_a_i;
        end else if (ex_valid_i && (md_op_i == MD_MTLO)) begin
          lo_d = src_a_i;
        end
      end
      StRun: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
          if (md_is_mul(op_q)) begin
            {hi_d, lo_d} = prod;
          end else if (!div_zero) begin
            hi_d = rem;
            lo_d = quo;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= MD_NONE;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: rtl/exec_stage_md.sv
// MIPS E stage: forwarding muxes, SrcB select, ALU and HI/LO result select around md_unit.
// Defining EXEC_OVF_EN adds the ovf_e signed add/sub overflow flag.
module exec_stage_md import exec_pkg::*; #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MUL_LAT = 5,
  parameter int unsigned DIV_LAT = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid_e,
  input  logic [DATA_W-1:0] rd1_e,
  input  logic [DATA_W-1:0] rd2_e,
  input  logic [DATA_W-1:0] alu_out_m,
  input  logic [DATA_W-1:0] result_w,
  input  logic [1:0]        fwd_a_e,
  input  logic [1:0]        fwd_b_e,
  input  logic [DATA_W-1:0] ext_imm_e,
  input  logic              alu_src_e,
  input  logic [2:0]        alu_ctrl_e,
  input  logic [2:0]        md_op_e,
  input  logic [1:0]        hilo_sel_e,
  output logic [DATA_W-1:0] alu_out_e,
  output logic [DATA_W-1:0] write_data_e,
`ifdef EXEC_OVF_EN
  output logic              ovf_e,
`endif
  output logic              md_busy
);

  logic [DATA_W-1:0] src_a, fwd_b, src_b;
  logic [DATA_W-1:0] sum, diff, alu_res, hi, lo;

  always_comb begin
    case (fwd_a_e)
      FWD_W:   src_a = result_w;
      FWD_M:   src_a = alu_out_m;
      default: src_a = rd1_e;
    endcase
    case (fwd_b_e)
      FWD_W:   fwd_b = result_w;
      FWD_M:   fwd_b = alu_out_m;
      default: fwd_b = rd2_e;
    endcase
  end

  assign src_b        = alu_src_e ? ext_imm_e : fwd_b;
  assign write_data_e = fwd_b;
  assign sum          = src_a + src_b;
  assign diff         = src_a - src_b;

  always_comb begin
    case (alu_ctrl_e)
      ALU_ADDU, ALU_ADD: alu_res = sum;
      ALU_SUBU, ALU_SUB: alu_res = diff;
      ALU_AND:           alu_res = src_a & src_b;
      ALU_OR:            alu_res = src_a | src_b;
      ALU_XOR:           alu_res = src_a ^ src_b;
      ALU_SLT:           alu_res = DATA_W'($signed(src_a) < $signed(src_b));
      default:           alu_res = sum;
    endcase
  end

  always_comb begin
    case (hilo_sel_e)
      HILO_HI: alu_out_e = hi;
      HILO_LO: alu_out_e = lo;
      default: alu_out_e = alu_res;
    endcase
  end

`ifdef EXEC_OVF_EN
  logic add_ovf, sub_ovf;
  assign add_ovf = (src_a[DATA_W-1] == src_b[DATA_W-1]) && (sum[DATA_W-1] != src_a[DATA_W-1]);
  assign sub_ovf = (src_a[DATA_W-1] != src_b[DATA_W-1]) && (diff[DATA_W-1] != src_a[DATA_W-1]);
  assign ovf_e   = ex_valid_e & (((alu_ctrl_e == ALU_ADD) & add_ovf) |
                                 ((alu_ctrl_e == ALU_SUB) & sub_ovf));
`endif

  md_unit #(
    .DATA_W  (DATA_W),
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) u_md_unit (
    .clk        (clk),
    .reset      (reset),
    .ex_valid_i (ex_valid_e),
    .md_op_i    (md_op_e),
    .src_a_i    (src_a),
    .src_b_i    (fwd_b),
    .hi_o       (hi),
    .lo_o       (lo),
    .md_busy_o  (md_busy)
  );

endmodule
